// File: rtl/rdma_rd_req_responder.sv
// rdma_rd_req_responder
// User-side stand-in for host/card memory on the RDMA local-read path.
// Accepts read commands on the rd_req metadata channel and streams back
// an address-derived payload: every 64-bit lane carries its own byte address.
// Optional build macro RDMA_RESP_STATS_EN adds saturating activity counters
// (cmd_cnt, beat_cnt_total, stall_cnt).

module rdma_rd_req_responder #(
    parameter int DATA_BITS = 512,
    parameter int REQ_BITS  = 128,
    parameter int LEN_BITS  = 28
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_rd_req_valid,
    output logic                   s_rd_req_ready,
    input  logic [REQ_BITS-1:0]    s_rd_req_data,
    output logic                   m_axis_rd_tvalid,
    input  logic                   m_axis_rd_tready,
    output logic [DATA_BITS-1:0]   m_axis_rd_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_rd_tkeep,
    output logic                   m_axis_rd_tlast,
    output logic                   zero_len_err
`ifdef RDMA_RESP_STATS_EN
    ,
    output logic [31:0]            cmd_cnt,
    output logic [31:0]            beat_cnt_total,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int BYTES    = DATA_BITS / 8;
    localparam int LANES    = DATA_BITS / 64;
    localparam int BSHIFT   = $clog2(BYTES);
    // One extra bit so that ceil((2^LEN_BITS-1)/BYTES) still fits.
    localparam int CNT_BITS = LEN_BITS + 1 - BSHIFT;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                armed;
    logic [CNT_BITS-1:0] beat_cnt;
    logic [CNT_BITS-1:0] beat_total;
    logic                last_q;
    logic [BYTES-1:0]    final_keep;

    logic [47:0]         cmd_vaddr;
    logic [LEN_BITS-1:0] cmd_len;
    logic                cmd_last;
    logic [LEN_BITS:0]   len_round;
    logic [CNT_BITS-1:0] cmd_beats;
    logic [BYTES-1:0]    keep_calc;
    logic                cmd_fire;
    logic                beat_fire;
    logic                is_final;
    logic                next_is_final;
    logic                unused_req_bits;

    assign cmd_vaddr       = s_rd_req_data[47:0];
    assign cmd_len         = s_rd_req_data[48 +: LEN_BITS];
    assign cmd_last        = s_rd_req_data[76];
    assign unused_req_bits = ^s_rd_req_data[REQ_BITS-1:77];

    assign len_round = {1'b0, cmd_len} + (LEN_BITS+1)'(BYTES - 1);
    assign cmd_beats = len_round[LEN_BITS:BSHIFT];

    assign cmd_fire      = s_rd_req_valid && s_rd_req_ready;
    assign beat_fire     = m_axis_rd_tvalid && m_axis_rd_tready;
    assign is_final      = (beat_cnt == beat_total - CNT_BITS'(1));
    assign next_is_final = ((beat_cnt + CNT_BITS'(2)) == beat_total);

    // Final-beat byte enables: low (len mod BYTES) bits, or all ones when the length is beat aligned.
    always_comb begin
        keep_calc = '1;
        if (cmd_len[BSHIFT-1:0] != '0) begin
            keep_calc = (BYTES'(1) << cmd_len[BSHIFT-1:0]) - BYTES'(1);
        end
    end

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a non-empty command opens a stream, the final beat closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_fire && (cmd_len != '0)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (beat_fire && is_final) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs depend only on registered state, so tready never reaches tvalid.
    always_comb begin
        s_rd_req_ready   = (state == IDLE) && armed;
        m_axis_rd_tvalid = (state == STREAM);
    end

    // Datapath: load beat 0 on acceptance, then step every lane by one beat of bytes per transfer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            armed           <= 1'b0;
            zero_len_err    <= 1'b0;
            beat_cnt        <= '0;
            beat_total      <= '0;
            last_q          <= 1'b0;
            final_keep      <= '0;
            m_axis_rd_tdata <= '0;
            m_axis_rd_tkeep <= '0;
            m_axis_rd_tlast <= 1'b0;
        end else begin
            armed        <= 1'b1;
            zero_len_err <= cmd_fire && (cmd_len == '0);
            if (cmd_fire && (cmd_len != '0)) begin
                beat_cnt   <= '0;
                beat_total <= cmd_beats;
                last_q     <= cmd_last;
                final_keep <= keep_calc;
                for (int k = 0; k < LANES; k++) begin
                    m_axis_rd_tdata[64*k +: 64] <= 64'(cmd_vaddr) + 64'(8 * k);
                end
                if (cmd_beats == CNT_BITS'(1)) begin
                    m_axis_rd_tkeep <= keep_calc;
                    m_axis_rd_tlast <= cmd_last;
                end else begin
                    m_axis_rd_tkeep <= '1;
                    m_axis_rd_tlast <= 1'b0;
                end
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + CNT_BITS'(1);
                if (is_final) begin
                    m_axis_rd_tdata <= '0;
                    m_axis_rd_tkeep <= '0;
                    m_axis_rd_tlast <= 1'b0;
                end else begin
                    for (int k = 0; k < LANES; k++) begin
                        m_axis_rd_tdata[64*k +: 64] <= m_axis_rd_tdata[64*k +: 64] + 64'(BYTES);
                    end
                    m_axis_rd_tkeep <= next_is_final ? final_keep : '1;
                    m_axis_rd_tlast <= next_is_final && last_q;
                end
            end
        end
    end

`ifdef RDMA_RESP_STATS_EN
    // Saturating activity counters: completed commands, transferred beats, stalled cycles.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cmd_cnt        <= '0;
            beat_cnt_total <= '0;
            stall_cnt      <= '0;
        end else begin
            if (beat_fire && is_final && (cmd_cnt != '1)) begin
                cmd_cnt <= cmd_cnt + 32'd1;
            end
            if (beat_fire && (beat_cnt_total != '1)) begin
                beat_cnt_total <= beat_cnt_total + 32'd1;
            end
            if (m_axis_rd_tvalid && !m_axis_rd_tready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rdma_rd_req_responder.sv
// tb_rdma_rd_req_responder
// Table-driven directed commands, hand sequences for zero-length, back-pressure,
// mid-stream reset and maximum length, then randomized commands checked
// against an arithmetic model of the address-derived payload.

module tb_rdma_rd_req_responder;

    localparam int DB    = 512;
    localparam int RB    = 128;
    localparam int LB    = 28;
    localparam int BYTES = DB / 8;

    logic          aclk;
    logic          areset;
    logic          s_rd_req_valid;
    logic          s_rd_req_ready;
    logic [RB-1:0] s_rd_req_data;
    logic          m_axis_rd_tvalid;
    logic          m_axis_rd_tready;
    logic [DB-1:0] m_axis_rd_tdata;
    logic [BYTES-1:0] m_axis_rd_tkeep;
    logic          m_axis_rd_tlast;
    logic          zero_len_err;
`ifdef RDMA_RESP_STATS_EN
    logic [31:0]   cmd_cnt;
    logic [31:0]   beat_cnt_total;
    logic [31:0]   stall_cnt;
`endif

    int vecCount  = 0;
    int missCount = 0;

    rdma_rd_req_responder #(
        .DATA_BITS(DB),
        .REQ_BITS (RB),
        .LEN_BITS (LB)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_rd_req_valid  (s_rd_req_valid),
        .s_rd_req_ready  (s_rd_req_ready),
        .s_rd_req_data   (s_rd_req_data),
        .m_axis_rd_tvalid(m_axis_rd_tvalid),
        .m_axis_rd_tready(m_axis_rd_tready),
        .m_axis_rd_tdata (m_axis_rd_tdata),
        .m_axis_rd_tkeep (m_axis_rd_tkeep),
        .m_axis_rd_tlast (m_axis_rd_tlast),
        .zero_len_err    (zero_len_err)
`ifdef RDMA_RESP_STATS_EN
        ,
        .cmd_cnt         (cmd_cnt),
        .beat_cnt_total  (beat_cnt_total),
        .stall_cnt       (stall_cnt)
`endif
    );

    // Free-running clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hard stop in case a wait somehow never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected beat: each 64-bit lane holds its byte address, arithmetic modulo 2^64.
    function automatic logic [DB-1:0] modelData(input logic [47:0] va, input int b);
        logic [DB-1:0] d;
        logic [63:0]   a;
        d = '0;
        for (int k = 0; k < DB / 64; k++) begin
            a = 64'(va) + 64'(b) * 64'(BYTES) + 64'(8 * k);
            d[64*k +: 64] = a;
        end
        return d;
    endfunction

    // Expected byte enables: full beats, partial final beat covering the leftover bytes.
    function automatic logic [BYTES-1:0] modelKeep(input logic [27:0] ln, input int b);
        int nBeats;
        int rem;
        logic [BYTES-1:0] kp;
        nBeats = (int'(ln) + BYTES - 1) / BYTES;
        rem    = int'(ln) % BYTES;
        kp     = '1;
        if (b == nBeats - 1 && rem != 0) begin
            kp = '0;
            for (int i = 0; i < rem; i++) kp[i] = 1'b1;
        end
        return kp;
    endfunction

    task automatic checkOutput(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        areset           = 1'b1;
        s_rd_req_valid   = 1'b0;
        s_rd_req_data    = '0;
        m_axis_rd_tready = 1'b0;
        @(negedge aclk);
        checkOutput("rst_ready",  s_rd_req_ready, 1'b0);
        checkOutput("rst_tvalid", m_axis_rd_tvalid, 1'b0);
        checkOutput("rst_tdata",  m_axis_rd_tdata, '0);
        checkOutput("rst_tkeep",  m_axis_rd_tkeep, '0);
        checkOutput("rst_tlast",  m_axis_rd_tlast, 1'b0);
        checkOutput("rst_zerr",   zero_len_err, 1'b0);
`ifdef RDMA_RESP_STATS_EN
        checkOutput("rst_cmd_cnt",   cmd_cnt, 0);
        checkOutput("rst_beat_tot",  beat_cnt_total, 0);
        checkOutput("rst_stall_cnt", stall_cnt, 0);
`endif
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("ready_after_reset", s_rd_req_ready, 1'b1);
    endtask

    // Issue one command and follow its beats. stallPct<0 selects readyPat bit per cycle.
    task automatic applyStimulus(
        input  logic [47:0] va,
        input  logic [27:0] ln,
        input  logic        lst,
        input  int          stallPct,
        input  logic [15:0] readyPat,
        input  int          stopAfter,
        input  int          probeIdx,
        output int          beatsSeen,
        output logic [63:0] probeLane0,
        output logic [63:0] lastKeep
    );
        int   nBeats;
        int   limit;
        int   budget;
        int   cyc;
        logic rdy;
        nBeats     = (int'(ln) + BYTES - 1) / BYTES;
        limit      = (nBeats < stopAfter) ? nBeats : stopAfter;
        budget     = 100 + limit * 20;
        beatsSeen  = 0;
        probeLane0 = '0;
        lastKeep   = '0;
        cyc        = 0;
        @(negedge aclk);
        s_rd_req_data        = '0;
        s_rd_req_data[47:0]  = va;
        s_rd_req_data[75:48] = ln;
        s_rd_req_data[76]    = lst;
        s_rd_req_valid       = 1'b1;
        m_axis_rd_tready     = 1'b0;
        checkOutput("cmd_ready", s_rd_req_ready, 1'b1);
        @(negedge aclk);
        s_rd_req_valid = 1'b0;
        while (beatsSeen < limit && cyc < budget) begin
            if (stallPct < 0) rdy = (cyc < 16) ? readyPat[cyc] : 1'b1;
            else              rdy = ($urandom_range(99) >= stallPct);
            m_axis_rd_tready = rdy;
            checkOutput("tvalid",     m_axis_rd_tvalid, 1'b1);
            checkOutput("ready_busy", s_rd_req_ready, 1'b0);
            checkOutput("tdata",      m_axis_rd_tdata, modelData(va, beatsSeen));
            checkOutput("tkeep",      m_axis_rd_tkeep, modelKeep(ln, beatsSeen));
            checkOutput("tlast",      m_axis_rd_tlast, (beatsSeen == nBeats - 1) && lst);
            if (rdy && m_axis_rd_tvalid) begin
                if (beatsSeen == probeIdx)   probeLane0 = m_axis_rd_tdata[63:0];
                if (beatsSeen == nBeats - 1) lastKeep   = 64'(m_axis_rd_tkeep);
                beatsSeen++;
            end
            @(negedge aclk);
            cyc++;
        end
        m_axis_rd_tready = 1'b0;
        checkOutput("beat_budget", beatsSeen, limit);
        if (limit == nBeats) begin
            checkOutput("tvalid_done", m_axis_rd_tvalid, 1'b0);
            checkOutput("ready_done",  s_rd_req_ready, 1'b1);
        end
    endtask

    typedef struct {
        logic [47:0] vaddr;
        logic [27:0] len;
        logic        last;
        int          stallPct;
        int          probeIdx;
        int          expBeats;
        logic [63:0] expProbe;
        logic [63:0] expKeep;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          seen;
        logic [63:0] probe;
        logic [63:0] kp;
        logic [63:0] r;
        logic [47:0] va;
        logic [27:0] ln;

        vecs[0] = '{48'h1000, 28'd64, 1'b1, 0, 0, 1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{48'h0, 28'd130, 1'b0, 0, 2, 3, 64'h80, 64'h3};
        vecs[2] = '{48'hFFFF_FFFF_FFC0, 28'd128, 1'b1, 0, 1, 2, 64'h0001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{48'h2000, 28'd65, 1'b1, 50, 1, 2, 64'h2040, 64'h1};
        vecs[4] = '{48'h123, 28'd63, 1'b0, 0, 0, 1, 64'h123, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[5] = '{48'h40, 28'd256, 1'b1, 30, 3, 4, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF};

        doReset();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].vaddr, vecs[i].len, vecs[i].last, vecs[i].stallPct,
                          16'hFFFF, 1 << 30, vecs[i].probeIdx, seen, probe, kp);
            checkOutput("tbl_beats", seen, vecs[i].expBeats);
            checkOutput("tbl_probe", probe, vecs[i].expProbe);
            checkOutput("tbl_keep",  kp, vecs[i].expKeep);
        end

        // Zero-length command: consumed, single error pulse, no data.
        @(negedge aclk);
        s_rd_req_data        = '0;
        s_rd_req_data[47:0]  = 48'h3000;
        s_rd_req_valid       = 1'b1;
        checkOutput("zl_ready", s_rd_req_ready, 1'b1);
        @(negedge aclk);
        s_rd_req_valid = 1'b0;
        checkOutput("zl_err_pulse", zero_len_err, 1'b1);
        checkOutput("zl_tvalid",    m_axis_rd_tvalid, 1'b0);
        checkOutput("zl_ready_back", s_rd_req_ready, 1'b1);
        @(negedge aclk);
        checkOutput("zl_err_clear", zero_len_err, 1'b0);
        checkOutput("zl_tvalid2",   m_axis_rd_tvalid, 1'b0);

        // Back-pressure 1-0-0-1 from a clean reset so the statistics are exact.
        doReset();
        applyStimulus(48'h9000, 28'd256, 1'b1, -1, 16'hFFF9, 1 << 30, 3, seen, probe, kp);
        checkOutput("bp_beats", seen, 4);
        checkOutput("bp_probe", probe, 64'h90C0);
`ifdef RDMA_RESP_STATS_EN
        checkOutput("bp_cmd_cnt",   cmd_cnt, 1);
        checkOutput("bp_beat_tot",  beat_cnt_total, 4);
        checkOutput("bp_stall_cnt", stall_cnt, 2);
`endif

        // Reset after the first of four beats: outputs clear at once, next command starts from beat 0.
        applyStimulus(48'h5000, 28'd256, 1'b1, 0, 16'hFFFF, 1, 0, seen, probe, kp);
        areset = 1'b1;
        #1;
        checkOutput("mr_tvalid", m_axis_rd_tvalid, 1'b0);
        checkOutput("mr_tdata",  m_axis_rd_tdata, '0);
        checkOutput("mr_tkeep",  m_axis_rd_tkeep, '0);
        checkOutput("mr_tlast",  m_axis_rd_tlast, 1'b0);
        checkOutput("mr_ready",  s_rd_req_ready, 1'b0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("mr_ready_back", s_rd_req_ready, 1'b1);
        checkOutput("mr_tvalid_idle", m_axis_rd_tvalid, 1'b0);
        applyStimulus(48'h7000, 28'd192, 1'b0, 20, 16'hFFFF, 1 << 30, 0, seen, probe, kp);
        checkOutput("mr_new_beats", seen, 3);
        checkOutput("mr_new_probe", probe, 64'h7000);

        // Maximum length: first beats must be full and non-final, then abandon via reset.
        applyStimulus(48'hABC, 28'hFFF_FFFF, 1'b1, 0, 16'hFFFF, 3, 2, seen, probe, kp);
        checkOutput("max_probe", probe, 64'hB3C);
        doReset();

        // Randomized commands against the model.
        for (int i = 0; i < 20; i++) begin
            r  = {$urandom(), $urandom()};
            va = r[47:0];
            if ($urandom_range(3) == 0) va = 48'hFFFF_FFFF_FF00 | 48'(r[7:0]);
            ln = 28'($urandom_range(700, 1));
            applyStimulus(va, ln, 1'($urandom_range(1)), 40, 16'hFFFF, 1 << 30, 0, seen, probe, kp);
            checkOutput("rnd_probe", probe, 64'(va));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
